// File: rtl/data_sram_responder.sv
// data_sram_responder: single-port word SRAM behind an en/wen request port with optional stall cycles.
// Defining DSRAM_ALIGN_CHECK_EN enables misaligned-store suppression and the sticky addr_err flag.
module data_sram_responder #(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic        stallreq_for_mem,
  output logic        addr_err
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LP_N  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                r_state, w_state_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic                  w_stall;
  logic [3:0]            r_wen;
  logic [31:0]           r_addr, r_wdata;
  logic                  w_accept, w_perform, w_read, w_store_ok;
  logic [3:0]            w_acc_wen, w_lane_we;
  logic [31:0]           w_acc_addr, w_acc_wdata;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_rdata;
  logic                  r_resp_valid;
  logic                  w_unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        if (data_sram_en && LP_N != 4'd0) begin
          w_stall = 1'b1;
          if (LP_N == 4'd1) begin
            w_state_next = DONE;
          end else begin
            w_state_next = WAIT;
            w_cnt_next   = LP_N - 4'd1;
          end
        end
      end
      WAIT: begin
        w_stall    = 1'b1;
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) && data_sram_en;

  // Request is captured on accept so that DONE ignores whatever the pipeline drives meanwhile.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wen   <= data_sram_wen;
      r_addr  <= data_sram_addr;
      r_wdata <= data_sram_wdata;
    end
  end

  assign w_acc_wen   = (r_state == DONE) ? r_wen   : data_sram_wen;
  assign w_acc_addr  = (r_state == DONE) ? r_addr  : data_sram_addr;
  assign w_acc_wdata = (r_state == DONE) ? r_wdata : data_sram_wdata;
  assign w_perform   = !rst && ((w_accept && LP_N == 4'd0) || r_state == DONE);
  assign w_read      = w_perform && (w_acc_wen == 4'b0000);
  assign w_idx       = w_acc_addr[DEPTH_LOG2+1:2];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_we[gi] = w_perform && w_store_ok && w_acc_wen[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_lane_we[b]) r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata      <= '0;
      r_resp_valid <= 1'b0;
    end else begin
      r_resp_valid <= w_read;
      if (w_read) r_rdata <= r_mem[w_idx];
    end
  end

`ifdef DSRAM_ALIGN_CHECK_EN
  logic r_addr_err;

  always_comb begin
    case ({w_acc_wen, w_acc_addr[1:0]})
      6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11,
      6'b0011_00, 6'b1100_10, 6'b1111_00: w_store_ok = 1'b1;
      default:                            w_store_ok = 1'b0;
    endcase
  end

  // Flag is raised when the offending store would have completed; an illegal store never writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_err <= 1'b0;
    end else if (w_perform && w_acc_wen != 4'b0000 && !w_store_ok) begin
      r_addr_err <= 1'b1;
    end
  end

  assign addr_err = r_addr_err;
`else
  assign w_store_ok = 1'b1;
  assign addr_err   = 1'b0;
`endif

  assign w_unused = &{1'b0, w_acc_addr[31:DEPTH_LOG2+2], w_acc_addr[1:0]};

  assign data_sram_rdata  = r_rdata;
  assign resp_valid       = r_resp_valid;
  assign stallreq_for_mem = w_stall && !rst;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: a zero-wait and a three-wait instance, both 16 words deep,
// checked every cycle against a transaction-level timeline model plus literal spot checks.
module tb_data_sram_responder;

  localparam int MAXC = 8192;
  localparam int BIG  = 1 << 30;

  logic        clk;
  logic        rst_v   [2];
  logic        en_v    [2];
  logic [3:0]  wen_v   [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [31:0] rdata_v [2];
  logic        rv_v    [2];
  logic        stall_v [2];
  logic        err_v   [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      data_sram_responder #(
        .DEPTH_LOG2 (4),
        .WAIT_CYCLES(gi * 3)
      ) u_dut (
        .clk             (clk),
        .rst             (rst_v[gi]),
        .data_sram_en    (en_v[gi]),
        .data_sram_wen   (wen_v[gi]),
        .data_sram_addr  (addr_v[gi]),
        .data_sram_wdata (wdata_v[gi]),
        .data_sram_rdata (rdata_v[gi]),
        .resp_valid      (rv_v[gi]),
        .stallreq_for_mem(stall_v[gi]),
        .addr_err        (err_v[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Timeline model: what each output must be in each cycle, derived from issue time and wait count.
  bit          exp_stall [2][MAXC];
  bit          exp_rv    [2][MAXC];
  logic [31:0] exp_val   [2][MAXC];
  bit          skip      [2][MAXC];
  bit          reset_at  [2][MAXC];
  logic [31:0] mem_m     [2][16];
  logic [31:0] cur_rdata [2];
  int          err_from  [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[inst%0d] cyc %0d: got %h, expected %h", nm, k, cyc, act, exp);
  endtask

  function automatic bit store_ok(input logic [3:0] w, input logic [31:0] a);
`ifdef DSRAM_ALIGN_CHECK_EN
    logic [3:0] onehot_at;
    onehot_at = 4'b0001 << a[1:0];
    return (w == onehot_at) || (w == 4'b0011 && a[1:0] == 2'd0) ||
           (w == 4'b1100 && a[1:0] == 2'd2) || (w == 4'b1111 && a[1:0] == 2'd0);
`else
    return (w != 4'b0000) || (a[1:0] != 2'd3) || 1'b1;
`endif
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cyc < MAXC) begin
        if (reset_at[k][cyc]) begin
          cur_rdata[k] = 32'h0;
          err_from[k]  = BIG;
        end
        if (!skip[k][cyc]) begin
          if (exp_rv[k][cyc]) cur_rdata[k] = exp_val[k][cyc];
          check("stall", k, 32'(stall_v[k]), 32'(exp_stall[k][cyc]));
          check("resp_valid", k, 32'(rv_v[k]), 32'(exp_rv[k][cyc]));
          check("rdata", k, rdata_v[k], cur_rdata[k]);
          check("addr_err", k, 32'(err_v[k]), 32'(cyc >= err_from[k]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in an idle cycle, then holds junk on the inputs until the instance is idle again.
  task automatic issue(input int k, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    int t, n, idx;
    logic [31:0] m;
    t   = cyc;
    n   = k * 3;
    idx = int'(a[5:2]);
    en_v[k] = 1'b1; wen_v[k] = w; addr_v[k] = a; wdata_v[k] = d;
    $display("txn inst%0d cyc %0d %s wen=%b addr=%h wdata=%h", k, t, (w == 0) ? "RD" : "WR", w, a, d);
    for (int i = 0; i < n; i++) exp_stall[k][t+i] = 1'b1;
    if (w == 4'b0000) begin
      exp_rv[k][t+n+1]  = 1'b1;
      exp_val[k][t+n+1] = mem_m[k][idx];
    end else if (store_ok(w, a)) begin
      m = mem_m[k][idx];
      for (int b = 0; b < 4; b++) if (w[b]) m[8*b +: 8] = d[8*b +: 8];
      mem_m[k][idx] = m;
    end else if (err_from[k] > t + n + 1) begin
      err_from[k] = t + n + 1;
    end
    step();
    for (int i = 0; i < n; i++) begin
      en_v[k] = 1'($urandom_range(0, 1)); wen_v[k] = 4'($urandom);
      addr_v[k] = $urandom; wdata_v[k] = $urandom;
      step();
    end
    en_v[k] = 1'b0;
  endtask

  // Legal store accepted, then reset in the following cycle: the store must never land.
  task automatic store_then_reset(input int k, input logic [31:0] a, input logic [31:0] d);
    int t;
    t = cyc;
    en_v[k] = 1'b1; wen_v[k] = 4'b1111; addr_v[k] = a; wdata_v[k] = d;
    $display("txn inst%0d cyc %0d WR+RST addr=%h wdata=%h", k, t, a, d);
    exp_stall[k][t] = 1'b1;
    step();
    rst_v[k] = 1'b1; en_v[k] = 1'b1; addr_v[k] = $urandom;
    skip[k][t+1] = 1'b1;
    step();
    rst_v[k] = 1'b0; en_v[k] = 1'b0;
    reset_at[k][t+2] = 1'b1;
  endtask

  initial begin
    logic [3:0] w;
    logic [3:0] wen_pick [8];
    wen_pick = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0110};
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; en_v[k] = 1'b0; wen_v[k] = '0; addr_v[k] = '0; wdata_v[k] = '0;
      err_from[k] = BIG; cur_rdata[k] = 32'h0;
      skip[k][0] = 1'b1; skip[k][1] = 1'b1; skip[k][2] = 1'b1;
      reset_at[k][3] = 1'b1;
    end
    repeat (3) step();
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    check("reset_rdata", 0, rdata_v[0], 32'h0);
    check("reset_stall", 1, 32'(stall_v[1]), 32'h0);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) issue(k, 4'b1111, 32'(i * 4), $urandom);

    issue(0, 4'b1111, 32'h10, 32'hDEADBEEF);
    issue(0, 4'b0000, 32'h10, 32'h0);
    check("lit_rdata_deadbeef", 0, rdata_v[0], 32'hDEADBEEF);
    check("lit_resp_valid", 0, 32'(rv_v[0]), 32'h1);
    issue(0, 4'b1111, 32'h10, 32'h11223344);
    issue(0, 4'b0010, 32'h11, 32'h0000AB00);
    issue(0, 4'b0000, 32'h10, 32'h0);
    check("lit_byte_lane", 0, rdata_v[0], 32'h1122AB44);
    issue(0, 4'b1111, 32'h40, 32'h5);
    issue(0, 4'b0000, 32'h00, 32'h0);
    check("lit_wrap", 0, rdata_v[0], 32'h5);
    issue(0, 4'b1111, 32'h10, 32'hA5A5A5A5);
    issue(0, 4'b1111, 32'h12, 32'h12345678);
    issue(0, 4'b0000, 32'h10, 32'h0);
`ifdef DSRAM_ALIGN_CHECK_EN
    check("lit_misaligned_data", 0, rdata_v[0], 32'hA5A5A5A5);
    check("lit_misaligned_err", 0, 32'(err_v[0]), 32'h1);
`else
    check("lit_misaligned_data", 0, rdata_v[0], 32'h12345678);
    check("lit_misaligned_err", 0, 32'(err_v[0]), 32'h0);
`endif

    issue(1, 4'b1111, 32'h20, 32'hCAFEF00D);
    issue(1, 4'b0000, 32'h20, 32'h0);
    check("lit_wait_read", 1, rdata_v[1], 32'hCAFEF00D);
    check("lit_wait_rv", 1, 32'(rv_v[1]), 32'h1);
    store_then_reset(1, 32'h20, 32'h0BADF00D);
    check("lit_post_rst_rdata", 1, rdata_v[1], 32'h0);
    check("lit_post_rst_stall", 1, 32'(stall_v[1]), 32'h0);
    step();
    check("lit_post_rst_rv", 1, 32'(rv_v[1]), 32'h0);
    issue(1, 4'b0000, 32'h20, 32'h0);
    check("lit_rst_discard", 1, rdata_v[1], 32'hCAFEF00D);

    for (int k = 0; k < 2; k++) begin
      repeat (120) begin
        case ($urandom_range(0, 3))
          0: begin
            en_v[k] = 1'b0; wen_v[k] = 4'($urandom); addr_v[k] = $urandom;
            step();
          end
          1: issue(k, 4'b0000, $urandom, $urandom);
          default: begin
            w = wen_pick[$urandom_range(0, 7)];
            issue(k, w, $urandom, $urandom);
          end
        endcase
      end
    end

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 12, sets the word count of the internal data memory to 2^DEPTH_LOG2.
REQ-002 Parameter WAIT_CYCLES, default 0, sets the number of stall cycles inserted per access (legal range 0-15).
REQ-003 Port clk, input, 1 bit, is the clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit, is the reset: synchronous, active-high.
REQ-005 Port data_sram_en, input, 1 bit, SHALL mark a valid request in the current cycle.
REQ-006 Port data_sram_wen, input, 4 bits, SHALL carry byte-lane write enables, where bit i enables byte i; the value 0 with en=1 SHALL denote a read.
REQ-007 Port data_sram_addr, input, 32 bits, is the byte address of the request.
REQ-008 Port data_sram_wdata, input, 32 bits, is the lane-aligned store data.
REQ-009 Port data_sram_rdata, output, 32 bits, SHALL carry the full word returned for the most recent read.
REQ-010 Port resp_valid, output, 1 bit, SHALL pulse for one cycle when data_sram_rdata is updated by a read.
REQ-011 Port stallreq_for_mem, output, 1 bit, SHALL request a pipeline freeze while an access is pending.
REQ-012 Port addr_err, output, 1 bit, is a sticky misaligned-store flag.

Function
REQ-013 Word index SHALL be addr[DEPTH_LOG2+1:2]; upper address bits SHALL be ignored, so addresses alias modulo the memory size.
REQ-014 FSM states SHALL be IDLE, WAIT and DONE; only IDLE accepts requests.
REQ-015 With WAIT_CYCLES=0, a request accepted in cycle T SHALL be performed at the end of T; read data and resp_valid=1 SHALL appear in T+1; stallreq_for_mem SHALL stay 0.
REQ-016 With WAIT_CYCLES=N>0, the accept cycle T SHALL assert stallreq_for_mem combinationally and latch en/wen/addr/wdata.
REQ-017 The FSM SHALL then move to WAIT with counter N-1, or directly to DONE when N=1.
REQ-018 WAIT SHALL hold stallreq_for_mem=1, decrement the counter each cycle, and go to DONE when the counter reaches 0.
REQ-019 DONE (cycle T+N) SHALL hold stallreq_for_mem=0, perform the latched access at the end of the cycle, and ignore the inputs (no re-accept of the held request).
REQ-020 DONE SHALL then return to IDLE; for a read, rdata and resp_valid=1 SHALL appear in T+N+1.
REQ-021 Writes SHALL update only the bytes whose wen bit is 1; the other bytes are unchanged.
REQ-022 data_sram_rdata SHALL hold its value until the next completed read; writes never alter it.
REQ-023 The block is single-port: at most one access is in flight; input activity outside IDLE SHALL be ignored.
REQ-024 Write-then-read of the same word in consecutive accepted requests SHALL return the newly written bytes.
REQ-025 en=0 in IDLE SHALL leave the state, memory and outputs unchanged, except that resp_valid returns to 0.

Reset
REQ-026 On rst, the FSM SHALL go to IDLE and the counter to 0.
REQ-027 On rst, data_sram_rdata, resp_valid, stallreq_for_mem and addr_err SHALL be 0.
REQ-028 Memory contents are not cleared by rst.
REQ-029 rst during WAIT or DONE SHALL discard the pending access; no memory write occurs and no resp_valid pulse follows.

Configuration
REQ-030 Macro DSRAM_ALIGN_CHECK_EN, when defined, SHALL check each accepted store; legal (wen, addr[1:0]) pairs are:
  - one-hot wen with the set bit equal to addr[1:0]
  - 0011 with addr[1:0]=00
  - 1100 with addr[1:0]=10
  - 1111 with addr[1:0]=00
REQ-031 With DSRAM_ALIGN_CHECK_EN defined, an illegal store SHALL suppress the write, still complete with normal stall timing, and set addr_err until rst.
REQ-032 With DSRAM_ALIGN_CHECK_EN undefined, no check is made, every store writes per wen, and addr_err is tied to 0.
REQ-033 Reads are never checked.

Verification
REQ-034 N=0: write 0xDEADBEEF with wen=1111 at 0x10, then read 0x10 -> rdata=0xDEADBEEF with resp_valid=1 in the cycle after the read.
REQ-035 N=0: wen=0010 with wdata=0x0000AB00 at 0x11 over 0x11223344 at word 0x10, then read -> 0x1122AB44.
REQ-036 N=3: read accepted in cycle T -> stallreq_for_mem=1 in T..T+2 and 0 in T+3; rdata and resp_valid=1 in T+4; input changes in T+1..T+3 are ignored.
REQ-037 N=3: rst asserted in T+1 of a store -> target word unchanged on a later read, stallreq_for_mem=0 and resp_valid=0 from the cycle after rst.
REQ-038 With DSRAM_ALIGN_CHECK_EN: store wen=1111 at 0x12 -> memory unchanged and addr_err=1 stays 1 until rst; without the macro the same store writes the word at 0x10 and addr_err stays 0.
REQ-039 DEPTH_LOG2=4: write 0x5 at 0x40, then read 0x00 -> 0x5 (address wrap-around).
